// File: rtl/lcd_arb_pkg.sv
// lcd_arb_pkg: shared state encoding and width helper for the LCD update arbiter.
package lcd_arb_pkg;
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_WAIT_REL = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin pick, searching upward from ptr with wrap.
module rr_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]        req_i,
    input  logic [clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]        gnt_o
);
    logic [N_REQ-1:0] hi;
    logic [N_REQ-1:0] lo;

    // hi holds the lowest request at or above ptr, lo the lowest below it (the wrapped part)
    always_comb begin
        hi = '0;
        lo = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                if (i >= int'(ptr_i)) hi = N_REQ'(1) << i;
                else lo = N_REQ'(1) << i;
            end
        end
        gnt_o = |hi ? hi : lo;
    end
endmodule

// File: rtl/lcd_update_arbiter.sv
// lcd_update_arbiter: round-robin share of one LCD driver port, running the
// LCDUpdate/LCDAck 4-phase handshake with an ack timeout and per-requester done/error.
module lcd_update_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int DATA_W      = 16,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic                      Clk_i,
    input  logic                      Rst_i,
    input  logic [N_REQ-1:0]          ReqValid_i,
    input  logic [N_REQ*DATA_W-1:0]   ReqData_i,
    output logic [N_REQ-1:0]          ReqDone_o,
    output logic                      ReqErr_o,
    output logic                      LCDUpdate_o,
    output logic [DATA_W-1:0]         LCDData_o,
    input  logic                      LCDAck_i,
    output logic                      Busy_o,
    output logic [clog2(N_REQ)-1:0]   GrantIdx_o
);
    localparam int IW = clog2(N_REQ);
    localparam int CW = clog2(ACK_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     ptr_q, ptr_d, grant_q, grant_d, gnt_idx, nxt;
    logic [N_REQ-1:0]  done_q, done_d, gnt;
    logic              err_q, err_d, upd_q, upd_d, busy_q, busy_d;
    logic [DATA_W-1:0] data_q, data_d;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i (ReqValid_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (gnt[i]) gnt_idx = IW'(i);
    end

    assign nxt = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    // No grant while ReqDone is showing: the served requester may still hold ReqValid that cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = 1'b0;
        upd_d   = upd_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (|ReqValid_i && !(|done_q)) begin
                    state_d = S_WAIT_ACK;
                    data_d  = ReqData_i[int'(gnt_idx)*DATA_W +: DATA_W];
                    grant_d = gnt_idx;
                    cnt_d   = '0;
                    upd_d   = 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (LCDAck_i) begin
                    upd_d   = 1'b0;
                    state_d = S_WAIT_REL;
                end else if (cnt_q == CW'(ACK_TIMEOUT)) begin
                    upd_d   = 1'b0;
                    done_d  = N_REQ'(1) << grant_q;
                    err_d   = 1'b1;
                    ptr_d   = nxt;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_REL: begin
                if (!LCDAck_i) begin
                    done_d  = N_REQ'(1) << grant_q;
                    ptr_d   = nxt;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            upd_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            upd_q   <= upd_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign ReqDone_o   = done_q;
    assign ReqErr_o    = err_q;
    assign LCDUpdate_o = upd_q;
    assign LCDData_o   = data_q;
    assign Busy_o      = busy_q;
    assign GrantIdx_o  = grant_q;
endmodule

// File: tb/tb_lcd_update_arbiter.sv
// tb_lcd_update_arbiter: randomized scoreboard bench; the stimulus predicts each winner
// from pending requests and the round-robin pointer, a monitor checks what the DUT presents.
module tb_lcd_update_arbiter;
    localparam int N = 3;
    localparam int W = 16;
    localparam int T = 8;

    logic           Clk_i = 1'b0;
    logic           Rst_i = 1'b1;
    logic           LCDAck_i = 1'b0;
    logic [N-1:0]   ReqValid_i = '0;
    logic [N*W-1:0] ReqData_i = '0;
    logic [N-1:0]   ReqDone_o;
    logic           ReqErr_o;
    logic           LCDUpdate_o;
    logic [W-1:0]   LCDData_o;
    logic           Busy_o;
    logic [1:0]     GrantIdx_o;

    lcd_update_arbiter #(.N_REQ(N), .DATA_W(W), .ACK_TIMEOUT(T)) dut (
        .Clk_i       (Clk_i),
        .Rst_i       (Rst_i),
        .ReqValid_i  (ReqValid_i),
        .ReqData_i   (ReqData_i),
        .ReqDone_o   (ReqDone_o),
        .ReqErr_o    (ReqErr_o),
        .LCDUpdate_o (LCDUpdate_o),
        .LCDData_o   (LCDData_o),
        .LCDAck_i    (LCDAck_i),
        .Busy_o      (Busy_o),
        .GrantIdx_o  (GrantIdx_o)
    );

    always #5 Clk_i = ~Clk_i;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
        bit           err;
        int           hi;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ptr_m = 0;
    int   mon_hi = 0;
    bit   mon_prev = 0;
    exp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(negedge Clk_i);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [W-1:0] d);
        ReqValid_i[i] = 1'b1;
        ReqData_i[i*W +: W] = d;
    endtask

    // ack_k < 0 means never acknowledge; otherwise ack after ack_k high cycles, held lvl cycles
    task automatic run_txn(input int ack_k, input int lvl, input bit keep, input int lat, input bit mutate);
        int   w;
        int   n;
        bit   seen;
        exp_t e;
        w = pick(ReqValid_i, ptr_m);
        e.idx = w;
        e.data = ReqData_i[w*W +: W];
        e.err = ack_k < 0;
        e.hi = (ack_k < 0) ? T + 1 : ack_k + 1;
        exp_q.push_back(e);
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            tick();
            n++;
            seen = LCDUpdate_o;
        end
        if (!seen) begin
            chk("upd_rise_timeout", 0, 1);
            return;
        end
        if (lat > 0) chk("grant_latency", n, lat);
        chk("busy_high", Busy_o, 1);
        if (mutate) begin
            ReqValid_i[w] = 1'b0;
            ReqData_i[w*W +: W] = ~e.data;
        end
        if (ack_k >= 0) begin
            repeat (ack_k) tick();
            LCDAck_i = 1'b1;
            repeat (lvl) tick();
            chk("done_during_ack", ReqDone_o, 0);
            LCDAck_i = 1'b0;
            tick();
            chk("done_latency", ReqDone_o != 0, 1);
        end else begin
            n = 0;
            while (ReqDone_o == 0 && n < T + 6) begin
                tick();
                n++;
            end
            chk("timeout_done", ReqDone_o != 0, 1);
        end
        chk("busy_after_done", Busy_o, 0);
        ptr_m = (w + 1) % N;
        if (!keep) ReqValid_i[w] = 1'b0;
    endtask

    always @(posedge Clk_i) begin
        #2;
        if (Rst_i) begin
            mon_hi = 0;
            mon_prev = 0;
        end else begin
            chk("done_onehot_errqual", ($countones(ReqDone_o) > 1) || (ReqErr_o && ReqDone_o == 0), 0);
            if (LCDUpdate_o) begin
                if (exp_q.size() == 0) chk("upd_unexpected", 1, 0);
                else begin
                    if (!mon_prev) chk("grant_idx", GrantIdx_o, exp_q[0].idx);
                    chk("lcd_data", LCDData_o, exp_q[0].data);
                end
                mon_hi++;
            end else if (mon_prev) begin
                if (exp_q.size() > 0) chk("upd_high_cycles", mon_hi, exp_q[0].hi);
                mon_hi = 0;
            end
            if (ReqDone_o != 0) begin
                if (exp_q.size() == 0) chk("done_unexpected", ReqDone_o, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("done_vec", ReqDone_o, 1 << mon_e.idx);
                    chk("done_err", ReqErr_o, mon_e.err);
                end
            end
            mon_prev = LCDUpdate_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int ack_k;
        int mode;
        repeat (2) tick();
        chk("rst_upd", LCDUpdate_o, 0);
        chk("rst_data", LCDData_o, 0);
        chk("rst_grant", GrantIdx_o, 0);
        chk("rst_busy", Busy_o, 0);
        chk("rst_done", ReqDone_o, 0);
        chk("rst_err", ReqErr_o, 0);
        Rst_i = 1'b0;
        tick();

        // contention from reset: held requests alternate 0,1,0,1
        set_req(0, 16'h1111);
        set_req(1, 16'h2222);
        run_txn(0, 1, 1, 1, 0);
        run_txn(1, 1, 1, 2, 0);
        run_txn(2, 2, 1, 2, 0);
        run_txn(0, 1, 1, 2, 0);
        ReqValid_i = '0;
        repeat (3) tick();

        // stray ack while idle
        LCDAck_i = 1'b1;
        tick();
        LCDAck_i = 1'b0;
        repeat (3) tick();
        chk("stray_ack_done", ReqDone_o, 0);
        chk("stray_ack_busy", Busy_o, 0);

        // single request, 1-cycle ack
        set_req(0, 16'h00A5);
        run_txn(0, 1, 0, 1, 0);

        // timeout, then a normal transaction
        set_req(1, 16'hBEEF);
        run_txn(-1, 0, 0, 0, 0);
        set_req(2, 16'h0C0C);
        run_txn(3, 1, 0, 2, 0);

        // ack exactly at the timeout count, then a 5-cycle level ack
        set_req(0, 16'h7E57);
        run_txn(T, 1, 0, 2, 0);
        set_req(1, 16'h5A5A);
        run_txn(2, 5, 0, 2, 0);

        // request dropped and payload changed after grant
        set_req(2, 16'h1234);
        run_txn(1, 1, 0, 2, 0);
        set_req(0, 16'hCAFE);
        run_txn(1, 1, 0, 2, 1);
        repeat (2) tick();

        // reset mid-transaction: req1 in flight, afterwards req0 wins again
        set_req(1, 16'hD1D1);
        set_req(0, 16'hD0D0);
        begin
            exp_t e;
            int   n;
            e.idx = pick(ReqValid_i, ptr_m);
            e.data = ReqData_i[e.idx*W +: W];
            e.err = 0;
            e.hi = 0;
            exp_q.push_back(e);
            n = 0;
            while (!LCDUpdate_o && n < 20) begin
                tick();
                n++;
            end
            chk("rst_mid_rise", LCDUpdate_o, 1);
        end
        repeat (2) tick();
        Rst_i = 1'b1;
        tick();
        chk("rst_mid_upd", LCDUpdate_o, 0);
        chk("rst_mid_busy", Busy_o, 0);
        chk("rst_mid_done", ReqDone_o, 0);
        void'(exp_q.pop_back());
        Rst_i = 1'b0;
        ptr_m = 0;
        run_txn(0, 1, 0, 1, 0);
        run_txn(0, 1, 0, 2, 0);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            if (ReqValid_i == 0 || $urandom_range(0, 1) == 1)
                for (int i = 0; i < N; i++)
                    if (!ReqValid_i[i] && $urandom_range(0, 1) == 1) set_req(i, 16'($urandom));
            if (ReqValid_i == 0) set_req($urandom_range(0, N - 1), 16'($urandom));
            mode = $urandom_range(0, 9);
            ack_k = (mode == 0) ? -1 : (mode == 1) ? T : $urandom_range(0, T - 1);
            run_txn(ack_k, $urandom_range(1, 4), $urandom_range(0, 3) == 0, 0, 0);
        end
        ReqValid_i = '0;
        repeat (4) tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
